// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM macro.
// Reads return one cycle after acceptance on a shared response bus tagged per requester.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_data,
  input  logic                  r0_we,
  input  logic [MASK_WIDTH-1:0] r0_wmask,
  output logic                  r0_rsp_valid,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_data,
  input  logic                  r1_we,
  input  logic [MASK_WIDTH-1:0] r1_wmask,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_we,
  output logic [MASK_WIDTH-1:0] sram_wmask,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic [CNT_WIDTH-1:0]  r0_grants,
  output logic [CNT_WIDTH-1:0]  r1_grants
);

  logic                 r_ptr;
  logic                 r_rsp_vld_p1;
  logic                 r_rsp_id_p1;
  logic [CNT_WIDTH-1:0] r_r0_grants;
  logic [CNT_WIDTH-1:0] r_r1_grants;

  logic w_ok;
  logic w_gnt0;
  logic w_gnt1;
  logic w_acc;
  logic w_rsp;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Stage p0: grant decision and macro drive, all combinational in the acceptance cycle
  assign w_ok   = en & ~rst;
  assign w_gnt0 = w_ok & r0_valid & (~r1_valid | ~r_ptr);
  assign w_gnt1 = w_ok & r1_valid & (~r0_valid |  r_ptr);
  assign w_acc  = w_gnt0 | w_gnt1;

  assign r0_ready = w_gnt0;
  assign r1_ready = w_gnt1;

  always_comb begin
    sram_addr  = '0;
    sram_din   = '0;
    sram_we    = 1'b0;
    sram_wmask = '0;
    if (w_gnt0) begin
      sram_addr  = r0_addr;
      sram_din   = r0_data;
      sram_we    = r0_we;
      sram_wmask = r0_wmask;
    end else if (w_gnt1) begin
      sram_addr  = r1_addr;
      sram_din   = r1_data;
      sram_we    = r1_we;
      sram_wmask = r1_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= 1'b0;
      r_rsp_vld_p1 <= 1'b0;
      r_rsp_id_p1  <= 1'b0;
      r_r0_grants  <= '0;
      r_r1_grants  <= '0;
    end else begin
      if (w_gnt0) begin
        r_ptr       <= 1'b1;
        r_r0_grants <= sat_inc(r_r0_grants);
      end else if (w_gnt1) begin
        r_ptr       <= 1'b0;
        r_r1_grants <= sat_inc(r_r1_grants);
      end
      r_rsp_vld_p1 <= w_acc & ~sram_we;
      r_rsp_id_p1  <= w_gnt1;
    end
  end

  // Stage p1: macro data returns; reset in this cycle drops the response
  assign w_rsp        = r_rsp_vld_p1 & ~rst;
  assign r0_rsp_valid = w_rsp & ~r_rsp_id_p1;
  assign r1_rsp_valid = w_rsp &  r_rsp_id_p1;
  assign rsp_data     = w_rsp ? sram_dout : '0;

  assign r0_grants = r_r0_grants;
  assign r1_grants = r_r1_grants;

endmodule
